// File: rtl/ts_switch_scheduler.sv
// ts_switch_scheduler: moves the TS mux between channels only on packet boundaries.
// It drains the current packet, blanks output until the target sync byte arrives, then
// selects the target. It also applies a post-switch holdoff and an alignment timeout.
// Optional gap statistics (last_gap) are built when TS_SWITCH_GAP_STATS_EN is defined.
module ts_switch_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned HOLDOFF_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  req_channel,
    input  logic [3:0]  signal_present,
    input  logic [3:0]  pkt_sop,
    input  logic [3:0]  pkt_eop,
    output logic [1:0]  sel,
    output logic        out_gate,
    output logic        busy,
    output logic        switch_done,
    output logic        switch_fail,
    output logic [15:0] switch_count,
    output logic [19:0] last_gap
);
    localparam int unsigned CW  = 20;
    localparam int unsigned SCW = 16;

    typedef enum logic [1:0] {IDLE, ALIGN, LOCKED, DRAIN} state_t;

    state_t         state, state_n;
    logic [1:0]     target, target_n, sel_n;
    logic           gate_n, busy_n, done_n, fail_n;
    logic [CW-1:0]  tmo_cnt, tmo_n, tmo_inc;
    logic [CW-1:0]  hold_cnt, hold_n;
    logic [SCW-1:0] count_n;

    assign tmo_inc = tmo_cnt + CW'(1);

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            target       <= 2'd0;
            sel          <= 2'd0;
            out_gate     <= 1'b0;
            busy         <= 1'b0;
            switch_done  <= 1'b0;
            switch_fail  <= 1'b0;
            switch_count <= '0;
            tmo_cnt      <= '0;
            hold_cnt     <= '0;
        end else begin
            state        <= state_n;
            target       <= target_n;
            sel          <= sel_n;
            out_gate     <= gate_n;
            busy         <= busy_n;
            switch_done  <= done_n;
            switch_fail  <= fail_n;
            switch_count <= count_n;
            tmo_cnt      <= tmo_n;
            hold_cnt     <= hold_n;
        end
    end

    // Next-state and next-output decisions; priority: disable, fail, sop/eop, request
    always_comb begin
        state_n  = state;
        target_n = target;
        sel_n    = sel;
        gate_n   = out_gate;
        done_n   = 1'b0;
        fail_n   = 1'b0;
        tmo_n    = tmo_cnt;
        hold_n   = hold_cnt;

        if (!en) begin
            state_n = IDLE;
            gate_n  = 1'b0;
            tmo_n   = '0;
            hold_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    gate_n   = 1'b0;
                    target_n = req_channel;
                    tmo_n    = '0;
                    state_n  = ALIGN;
                end
                ALIGN: begin
                    gate_n = 1'b0;
                    tmo_n  = tmo_inc;
                    if (!signal_present[target] || tmo_inc == CW'(TIMEOUT_CYCLES)) begin
                        fail_n   = 1'b1;
                        target_n = sel;
                        tmo_n    = '0;
                    end else if (pkt_sop[target]) begin
                        sel_n   = target;
                        gate_n  = 1'b1;
                        done_n  = 1'b1;
                        hold_n  = CW'(HOLDOFF_CYCLES);
                        tmo_n   = '0;
                        state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    gate_n = 1'b1;
                    if (hold_cnt != '0) begin
                        hold_n = hold_cnt - CW'(1);
                    end else if (req_channel != sel && signal_present[req_channel]) begin
                        target_n = req_channel;
                        state_n  = DRAIN;
                    end
                end
                DRAIN: begin
                    gate_n = 1'b1;
                    if (pkt_eop[sel]) begin
                        gate_n  = 1'b0;
                        tmo_n   = '0;
                        state_n = ALIGN;
                    end else if (req_channel == sel) begin
                        state_n = LOCKED;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n  = (state_n == ALIGN) || (state_n == DRAIN);
        count_n = (done_n && switch_count != '1) ? switch_count + SCW'(1) : switch_count;
    end

`ifdef TS_SWITCH_GAP_STATS_EN
    logic [CW-1:0] gap_cnt, gap_n, gap_inc, last_gap_n;

    assign gap_inc = (gap_cnt == '1) ? gap_cnt : gap_cnt + CW'(1);

    // Blanked-cycle counter: cleared on fresh ALIGN entry, kept across fail retargets
    always_comb begin
        gap_n      = gap_cnt;
        last_gap_n = last_gap;
        if (!en) begin
            gap_n = '0;
        end else if (state != ALIGN) begin
            if (state_n == ALIGN) gap_n = '0;
        end else begin
            gap_n = gap_inc;
        end
        if (done_n) last_gap_n = gap_inc;
    end

    // Gap statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt  <= '0;
            last_gap <= '0;
        end else begin
            gap_cnt  <= gap_n;
            last_gap <= last_gap_n;
        end
    end
`else
    assign last_gap = '0;
`endif

endmodule

// File: tb/tb_ts_switch_scheduler.sv
// tb_ts_switch_scheduler: directed table-driven bench for ts_switch_scheduler.
// Built with TIMEOUT_CYCLES=16 and HOLDOFF_CYCLES=100; last_gap expectations follow
// TS_SWITCH_GAP_STATS_EN.
module tb_ts_switch_scheduler;
    localparam int unsigned TMO  = 16;
    localparam int unsigned HOLD = 100;
`ifdef TS_SWITCH_GAP_STATS_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  req_channel;
    logic [3:0]  signal_present;
    logic [3:0]  pkt_sop;
    logic [3:0]  pkt_eop;
    logic [1:0]  sel;
    logic        out_gate;
    logic        busy;
    logic        switch_done;
    logic        switch_fail;
    logic [15:0] switch_count;
    logic [19:0] last_gap;

    int n_chk  = 0;
    int n_fail = 0;

    ts_switch_scheduler #(.TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .req_channel    (req_channel),
        .signal_present (signal_present),
        .pkt_sop        (pkt_sop),
        .pkt_eop        (pkt_eop),
        .sel            (sel),
        .out_gate       (out_gate),
        .busy           (busy),
        .switch_done    (switch_done),
        .switch_fail    (switch_fail),
        .switch_count   (switch_count),
        .last_gap       (last_gap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  req;
        logic [3:0]  pres;
        logic [3:0]  sop;
        logic [3:0]  eop;
        int          n;
        bit          each;
        logic [1:0]  sel;
        logic        gate;
        logic        busy;
        logic        done;
        logic        fail;
        logic [15:0] cnt;
        logic [19:0] gap;
    } vec_t;

    vec_t tv[$];

    function automatic logic [19:0] gp(input logic [19:0] v);
        return v & {20{GAP_EN}};
    endfunction

    function automatic vec_t mk(input logic e, input logic [1:0] r, input logic [3:0] p,
                                input logic [3:0] s, input logic [3:0] x, input int n,
                                input bit each, input logic [1:0] es, input logic eg,
                                input logic eb, input logic ed, input logic ef,
                                input logic [15:0] ec, input logic [19:0] egap);
        vec_t v;
        v.en = e; v.req = r; v.pres = p; v.sop = s; v.eop = x; v.n = n; v.each = each;
        v.sel = es; v.gate = eg; v.busy = eb; v.done = ed; v.fail = ef; v.cnt = ec;
        v.gap = egap;
        return v;
    endfunction

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] es, input logic eg,
                           input logic eb, input logic ed, input logic ef,
                           input logic [15:0] ec, input logic [19:0] egap);
        chk({tag, " sel"}, 32'(sel), 32'(es));
        chk({tag, " out_gate"}, 32'(out_gate), 32'(eg));
        chk({tag, " busy"}, 32'(busy), 32'(eb));
        chk({tag, " switch_done"}, 32'(switch_done), 32'(ed));
        chk({tag, " switch_fail"}, 32'(switch_fail), 32'(ef));
        chk({tag, " switch_count"}, 32'(switch_count), 32'(ec));
        chk({tag, " last_gap"}, 32'(last_gap), 32'(egap));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        localparam logic [3:0] F = 4'hF;
        // Test 1: first switch from IDLE to ch2, sop after nine ALIGN cycles
        tv.push_back(mk(1, 2, F, 0, 0,  1, 0,  0, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 2, F, 0, 0,  9, 1,  0, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 2, F, 4, 0,  1, 0,  2, 1, 0, 1, 0, 1, gp(10)));
        // Holdoff: request ignored until counter is 0, DRAIN on the 101st edge
        tv.push_back(mk(1, 2, F, 0, 0,  9, 1,  2, 1, 0, 0, 0, 1, gp(10)));
        tv.push_back(mk(1, 1, F, 0, 0, 91, 1,  2, 1, 0, 0, 0, 1, gp(10)));
        tv.push_back(mk(1, 1, F, 0, 0,  1, 0,  2, 1, 1, 0, 0, 1, gp(10)));
        // Drain then ten blanked cycles, eop byte passed
        tv.push_back(mk(1, 1, F, 0, 0,  3, 1,  2, 1, 1, 0, 0, 1, gp(10)));
        tv.push_back(mk(1, 1, F, 0, 4,  1, 0,  2, 0, 1, 0, 0, 1, gp(10)));
        tv.push_back(mk(1, 1, F, 0, 0,  9, 1,  2, 0, 1, 0, 0, 1, gp(10)));
        tv.push_back(mk(1, 1, F, 2, 0,  1, 0,  1, 1, 0, 1, 0, 2, gp(10)));
        // Withdrawn request: DRAIN back to LOCKED with no gap or pulse
        tv.push_back(mk(1, 1, F, 0, 0,100, 1,  1, 1, 0, 0, 0, 2, gp(10)));
        tv.push_back(mk(1, 3, F, 0, 0,  1, 0,  1, 1, 1, 0, 0, 2, gp(10)));
        tv.push_back(mk(1, 0, F, 0, 0,  1, 0,  1, 1, 1, 0, 0, 2, gp(10)));
        tv.push_back(mk(1, 1, F, 0, 0,  1, 0,  1, 1, 0, 0, 0, 2, gp(10)));
        // Timeout: fail on the 16th ALIGN edge, retarget to ch1, then lock ch1
        tv.push_back(mk(1, 0, F, 0, 0,  1, 0,  1, 1, 1, 0, 0, 2, gp(10)));
        tv.push_back(mk(1, 0, F, 0, 2,  1, 0,  1, 0, 1, 0, 0, 2, gp(10)));
        tv.push_back(mk(1, 0, F, 0, 0, 15, 1,  1, 0, 1, 0, 0, 2, gp(10)));
        tv.push_back(mk(1, 0, F, 0, 0,  1, 0,  1, 0, 1, 0, 1, 2, gp(10)));
        tv.push_back(mk(1, 0, F, 0, 0,  1, 0,  1, 0, 1, 0, 0, 2, gp(10)));
        tv.push_back(mk(1, 0, F, 2, 0,  1, 0,  1, 1, 0, 1, 0, 3, gp(18)));
        // Target loss: fail retargets to ch1, later ch2 sop is ignored
        tv.push_back(mk(1, 1, F, 0, 0,100, 1,  1, 1, 0, 0, 0, 3, gp(18)));
        tv.push_back(mk(1, 2, F, 0, 0,  1, 0,  1, 1, 1, 0, 0, 3, gp(18)));
        tv.push_back(mk(1, 2, F, 0, 2,  1, 0,  1, 0, 1, 0, 0, 3, gp(18)));
        tv.push_back(mk(1, 2, 4'b1011, 0, 0, 1, 0, 1, 0, 1, 0, 1, 3, gp(18)));
        tv.push_back(mk(1, 2, F, 4, 0,  1, 0,  1, 0, 1, 0, 0, 3, gp(18)));
        tv.push_back(mk(1, 2, F, 2, 0,  1, 0,  1, 1, 0, 1, 0, 4, gp(3)));
        // Disable: IDLE, gate off, sel and count kept; re-enable enters ALIGN
        tv.push_back(mk(0, 2, F, 0, 0,  1, 0,  1, 0, 0, 0, 0, 4, gp(3)));
        tv.push_back(mk(1, 3, F, 0, 0,  1, 0,  1, 0, 1, 0, 0, 4, gp(3)));

        rst_n = 1'b0; en = 1'b0; req_channel = 2'd0;
        signal_present = 4'h0; pkt_sop = 4'h0; pkt_eop = 4'h0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tv[i]) begin
            en = tv[i].en; req_channel = tv[i].req; signal_present = tv[i].pres;
            pkt_sop = tv[i].sop; pkt_eop = tv[i].eop;
            for (int k = 0; k < tv[i].n; k++) begin
                @(posedge clk); #1;
                pkt_sop = 4'h0; pkt_eop = 4'h0;
                if (tv[i].each || k == tv[i].n - 1)
                    chk_all($sformatf("row%0d cyc%0d", i, k), tv[i].sel, tv[i].gate,
                            tv[i].busy, tv[i].done, tv[i].fail, tv[i].cnt, tv[i].gap);
            end
        end

        // Asynchronous reset while in ALIGN: outputs clear before the next edge
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_all("rst_held", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        en = 1'b1; req_channel = 2'd1; signal_present = 4'hF;
        @(posedge clk); #1;
        chk_all("post_rst", 0, 0, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
